instr_fetch_stage: RTL
======================

# instr_fetch_stage

Instruction fetch (IF) stage of the 5-stage RV32I pipeline. Holds the program counter and drives the program memory's byte address. Captures the returned instruction word into the IF/ID pipeline register. Applies hazard-unit stalls and EX-stage redirects (flushes), and optionally predicts branch and JAL targets by predecoding the fetched word.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded while reset is asserted.
- NOP_INSTR, 32'h0000_0013 (ADDI x0,x0,0), bubble word placed in IF/ID on reset and flush.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  from hazard unit; holds PC and IF/ID.
- redirect_valid  in  1  from EX; branch mispredict or resolved jump (JALR, or any jump when prediction is compiled out).
- redirect_pc  in  32  corrected target; bits [1:0] are ignored and forced to 00.
- imem_addr  out  32  byte address to program memory; equals PC.
- imem_data  in  32  instruction word; combinational, valid in the same cycle.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  32  PC of the IF/ID instruction.
- if_id_instr  out  32  instruction word.
- if_id_pred_taken  out  1  fetch predicted this instruction taken.
- if_id_pred_target  out  32  PC that fetch used as successor; EX compares this against the actual successor.

## Operation
- PC register: next-PC mux priority is reset > redirect_valid > stall > predicted/sequential next.
- Sequential next: PC+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Redirect: PC <= {redirect_pc[31:2],2'b00}. IF/ID is flushed: valid=0, instr=NOP_INSTR, pred_taken=0, and pc/pred_target keep their previous value.
- Stall without redirect: PC and all IF/ID fields hold.
- Normal advance: IF/ID <= {1, PC, imem_data, pred_taken, next_pc}; PC <= next_pc.
- Redirect and stall together: redirect wins. The wrong-path instruction must not survive a stall.
- Predecode is combinational on imem_data:
  - B-type (opcode 1100011): imm_b sign-extended, 13 bits.
  - JAL (opcode 1101111): imm_j sign-extended, 21 bits.
  - Target is PC+imm, modulo 2^32.

## Timing
- Reset values (held while reset is high):
  - PC=imem_addr=RESET_PC
  - if_id_valid=0
  - if_id_pc=0
  - if_id_instr=NOP_INSTR
  - if_id_pred_taken=0
  - if_id_pred_target=0
- Reset is asynchronous. Deassertion mid-cycle takes effect at the next rising edge. The first fetch is RESET_PC.
- Latency: an instruction at address A is presented at imem_addr in cycle n and appears in IF/ID in cycle n+1.
- Redirect penalty: the redirect is sampled at edge n, imem_addr=redirect target in cycle n+1, and IF/ID shows a bubble in cycle n+1.
- No request/ready handshake. The memory is assumed single-cycle combinational. imem_data is sampled only at a non-stalled, non-redirected edge.
- Reset asserted mid-stall or mid-redirect: reset values apply immediately.

## Configuration
- BRANCH_PREDICT_EN defined:
  - Static prediction. B-type is predicted taken if imm sign bit (instr[31]) =1, i.e. backward. JAL is always taken.
  - next_pc = predicted target when predicted taken.
  - if_id_pred_taken and if_id_pred_target reflect the prediction.
- Not defined:
  - next_pc is always PC+4.
  - if_id_pred_taken is always 0 and if_id_pred_target=PC+4.
  - All control-flow changes come through redirect.

## Structure
- The shared package riscv_pkg holds:
  - NOP constant.
  - Opcode constants OPC_BRANCH=7'b1100011 and OPC_JAL=7'b1101111.
  - Typedef if_id_t, a packed struct of valid, pc, instr, pred_taken, pred_target.
- One combinational sub-module, branch_predecoder:
  - Inputs: pc, instr.
  - Outputs: is_branch, is_jal, pred_taken, pred_target.
  - It is compiled to pred_taken=0 when BRANCH_PREDICT_EN is absent.
- The top holds the PC register, next-PC mux and IF/ID register.

## Test plan
- Reset: hold reset 3 cycles, then release.
  - During reset: imem_addr=0x0, if_id_valid=0, if_id_instr=0x00000013.
  - After release: imem_addr sequence is 0x0, 0x4, 0x8.
- Stall: assert stall for 2 cycles while imem_addr=0x8.
  - imem_addr stays 0x8 and IF/ID holds the 0x4 instruction.
  - After release, the 0x8 instruction enters IF/ID.
- Redirect plus stall in the same cycle, redirect_pc=0x17.
  - Next cycle: imem_addr=0x14, if_id_valid=0, if_id_instr=0x00000013.
- JAL 0xFF1FF06F (jal x0,-16) fetched at 0x18:
  - With the macro: next imem_addr=0x08, if_id_pred_taken=1, if_id_pred_target=0x08.
  - Without the macro: next imem_addr=0x1C, pred_taken=0.
- Forward beq (offset +20) at 0x08:
  - With the macro: predicted not taken, next imem_addr=0x0C.
  - A backward beq (offset -8) at 0x10 gives next imem_addr=0x08.
- Wrap: redirect_pc=0xFFFFFFFC with a non-branch word gives imem_addr 0xFFFFFFFC, then 0x00000000.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I pipeline.
//   NOP         - ADDI x0,x0,0, the pipeline bubble word.
//   OPC_BRANCH  - B-type major opcode.
//   OPC_JAL     - JAL major opcode.
//   if_id_t     - IF/ID pipeline register contents.
package riscv_pkg;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } if_id_t;

endpackage

// File: rtl/branch_predecoder.sv
// branch_predecoder: combinational predecode of the fetched word.
// Optional feature macro: BRANCH_PREDICT_EN (static prediction; when absent
// pred_taken is tied to 0 and all control flow changes arrive by redirect).
// Ports:
//   pc          in  32  address of instr
//   instr       in  32  fetched instruction word
//   is_branch   out 1   instr is B-type
//   is_jal      out 1   instr is JAL
//   pred_taken  out 1   fetch should follow pred_target
//   pred_target out 32  pc + immediate of the branch/JAL (mod 2^32)
module branch_predecoder
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        is_branch,
    output logic        is_jal,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    logic [31:0] imm_b;
    logic [31:0] imm_j;

    assign is_branch = (instr[6:0] == OPC_BRANCH);
    assign is_jal    = (instr[6:0] == OPC_JAL);

    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};

    assign pred_target = pc + (is_jal ? imm_j : imm_b);

`ifdef BRANCH_PREDICT_EN
    // Backward branches (negative offset, sign bit set) are usually loop
    // closers, so they are guessed taken; JAL always goes to its target.
    assign pred_taken = is_jal | (is_branch & instr[31]);
`else
    assign pred_taken = 1'b0;
`endif

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Holds the PC, drives the program memory address and captures the fetched
// word into the IF/ID register.
// Optional feature macro: BRANCH_PREDICT_EN (static branch/JAL prediction).
// Ports:
//   clk               in  1   system clock, rising edge
//   reset             in  1   asynchronous, active-high
//   stall             in  1   hazard unit hold of PC and IF/ID
//   redirect_valid    in  1   EX redirect (mispredict / resolved jump)
//   redirect_pc       in  32  corrected target, bits [1:0] ignored
//   imem_addr         out 32  byte address to program memory (= PC)
//   imem_data         in  32  instruction word, combinational same cycle
//   if_id_valid       out 1   IF/ID holds a real instruction
//   if_id_pc          out 32  PC of the IF/ID instruction
//   if_id_instr       out 32  IF/ID instruction word
//   if_id_pred_taken  out 1   fetch predicted this instruction taken
//   if_id_pred_target out 32  successor PC chosen by fetch
//
// Flow control: there is no handshake. At each rising edge the stage does
// exactly one of: reset, redirect (flush IF/ID, load target), stall (hold
// everything), or advance (capture imem_data, PC <= next_pc). Redirect
// outranks stall so a wrong-path word can never be held by a stall.
module instr_fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_pred_taken,
    output logic [31:0] if_id_pred_target
);

    logic [31:0] pc;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;
    if_id_t      if_id;

    logic        pd_is_branch;
    logic        pd_is_jal;
    logic        pd_pred_taken;
    logic [31:0] pd_pred_target;
    logic        take_pred;

    branch_predecoder u_predecoder (
        .pc          (pc),
        .instr       (imem_data),
        .is_branch   (pd_is_branch),
        .is_jal      (pd_is_jal),
        .pred_taken  (pd_pred_taken),
        .pred_target (pd_pred_target)
    );

    assign seq_pc    = pc + 32'd4;
    // Only control-flow words may steer fetch away from the sequential path.
    assign take_pred = pd_pred_taken & (pd_is_branch | pd_is_jal);
    assign next_pc   = take_pred ? pd_pred_target : seq_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc                <= RESET_PC;
            if_id.valid       <= 1'b0;
            if_id.pc          <= 32'h0;
            if_id.instr       <= NOP_INSTR;
            if_id.pred_taken  <= 1'b0;
            if_id.pred_target <= 32'h0;
        end else if (redirect_valid) begin
            // Flush: pc/pred_target are left as-is, only the bubble matters.
            pc               <= {redirect_pc[31:2], 2'b00};
            if_id.valid      <= 1'b0;
            if_id.instr      <= NOP_INSTR;
            if_id.pred_taken <= 1'b0;
        end else if (!stall) begin
            pc                <= next_pc;
            if_id.valid       <= 1'b1;
            if_id.pc          <= pc;
            if_id.instr       <= imem_data;
            if_id.pred_taken  <= take_pred;
            if_id.pred_target <= next_pc;
        end
    end

    assign imem_addr         = pc;
    assign if_id_valid       = if_id.valid;
    assign if_id_pc          = if_id.pc;
    assign if_id_instr       = if_id.instr;
    assign if_id_pred_taken  = if_id.pred_taken;
    assign if_id_pred_target = if_id.pred_target;

endmodule
